// File: rtl/sextium_sram_ctrl.sv
// sextium_sram_ctrl: bridges the core's level-handshake memory port to an
// asynchronous 16-bit SRAM. Reads hold OE low and writes hold WE low for
// WAIT_CYCLES+1 cycles. A write is framed by one setup cycle and one hold
// cycle with data driven. Every SRAM-facing output and mem_ack is registered.
//
// state   | meaning
// IDLE    | waiting for a request; write wins over read
// READ    | OE low, counting down the access time
// WSETUP  | data driven, WE still high
// WPULSE  | WE low, counting down the access time
// WHOLD   | WE high again, data still driven
// ACK     | mem_ack high for one cycle, SRAM deselected
// RELEASE | wait for the core to drop its request
module sextium_sram_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr_bus,
  input  logic [15:0] mem_bus_out,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [15:0] mem_bus_in,
  output logic        mem_ack,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, READ, WSETUP, WPULSE, WHOLD, ACK, RELEASE
  } state_t;

  state_t      state;
  logic [3:0]  count;
  logic [15:0] dq_out;
  logic        dq_en;

  // The data bus is only driven while a write frame is in progress.
  assign SRAM_DQ = dq_en ? dq_out : 16'hzzzz;

  // Access sequencer with registered strobes, capture register and ack pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 4'd0;
      mem_ack    <= 1'b0;
      mem_bus_in <= 16'h0000;
      SRAM_ADDR  <= 20'h00000;
      SRAM_CE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_WE_N  <= 1'b1;
      SRAM_LB_N  <= 1'b1;
      SRAM_UB_N  <= 1'b1;
      dq_out     <= 16'h0000;
      dq_en      <= 1'b0;
    end else begin
      mem_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_write) begin
            state     <= WSETUP;
            SRAM_ADDR <= {4'b0000, addr_bus};
            dq_out    <= mem_bus_out;
            dq_en     <= 1'b1;
            SRAM_CE_N <= 1'b0;
            SRAM_LB_N <= 1'b0;
            SRAM_UB_N <= 1'b0;
            SRAM_WE_N <= 1'b1;
            count     <= WAIT_LOAD;
          end else if (mem_read) begin
            state     <= READ;
            SRAM_ADDR <= {4'b0000, addr_bus};
            SRAM_CE_N <= 1'b0;
            SRAM_LB_N <= 1'b0;
            SRAM_UB_N <= 1'b0;
            SRAM_OE_N <= 1'b0;
            count     <= WAIT_LOAD;
          end
        end
        READ: begin
          if (count == 4'd0) begin
            mem_bus_in <= SRAM_DQ;
            SRAM_OE_N  <= 1'b1;
            SRAM_CE_N  <= 1'b1;
            SRAM_LB_N  <= 1'b1;
            SRAM_UB_N  <= 1'b1;
            mem_ack    <= 1'b1;
            state      <= ACK;
          end else begin
            count <= count - 4'd1;
          end
        end
        WSETUP: begin
          SRAM_WE_N <= 1'b0;
          state     <= WPULSE;
        end
        WPULSE: begin
          if (count == 4'd0) begin
            SRAM_WE_N <= 1'b1;
            state     <= WHOLD;
          end else begin
            count <= count - 4'd1;
          end
        end
        WHOLD: begin
          dq_en     <= 1'b0;
          SRAM_CE_N <= 1'b1;
          SRAM_LB_N <= 1'b1;
          SRAM_UB_N <= 1'b1;
          mem_ack   <= 1'b1;
          state     <= ACK;
        end
        ACK: begin
          state <= RELEASE;
        end
        RELEASE: begin
          // A request still held from the finished access must not restart.
          if (!mem_read && !mem_write) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sextium_sram_ctrl.sv
// Bench for sextium_sram_ctrl: three controllers (WAIT_CYCLES 1, 0, 15),
// each attached to its own behavioural asynchronous SRAM.
module tb_sextium_sram_ctrl;
  localparam int NDUT = 3;

  logic        clock;
  logic        reset;
  logic [15:0] addr_bus    [NDUT];
  logic [15:0] mem_bus_out [NDUT];
  logic        mem_read    [NDUT];
  logic        mem_write   [NDUT];
  wire  [15:0] mem_bus_in  [NDUT];
  wire         mem_ack     [NDUT];
  wire  [19:0] sram_addr   [NDUT];
  wire         ce_n        [NDUT];
  wire         oe_n        [NDUT];
  wire         we_n        [NDUT];
  wire         lb_n        [NDUT];
  wire         ub_n        [NDUT];
  wire  [15:0] dq_mon      [NDUT];
  wire         dq_en_mon   [NDUT];

  int n_cmp = 0;
  int n_bad = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    wire  [15:0] dq;
    logic [15:0] mem [65536];

    sextium_sram_ctrl #(.WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 15))) dut (
      .clock(clock), .reset(reset),
      .addr_bus(addr_bus[g]), .mem_bus_out(mem_bus_out[g]),
      .mem_read(mem_read[g]), .mem_write(mem_write[g]),
      .mem_bus_in(mem_bus_in[g]), .mem_ack(mem_ack[g]),
      .SRAM_ADDR(sram_addr[g]), .SRAM_DQ(dq),
      .SRAM_CE_N(ce_n[g]), .SRAM_OE_N(oe_n[g]), .SRAM_WE_N(we_n[g]),
      .SRAM_LB_N(lb_n[g]), .SRAM_UB_N(ub_n[g])
    );

    assign dq = (!ce_n[g] && !oe_n[g] && we_n[g]) ? mem[sram_addr[g][15:0]] : 16'hzzzz;
    assign dq_mon[g]    = dq;
    assign dq_en_mon[g] = dut.dq_en;

    always @(posedge clock) begin
      if (!ce_n[g] && !we_n[g]) mem[sram_addr[g][15:0]] <= dq;
    end
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 15);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Start at #1 after an edge with the controller idle; leaves it idle again.
  task automatic do_access(input int k, input bit wr, input bit rd, input logic [15:0] a,
                           input logic [15:0] d, input logic [15:0] exp_rd,
                           input int hold, input string tag);
    int w, lat, oe_cyc, we_cyc, bad, extra;
    bit acked;
    w = wait_of(k);
    lat = 0; oe_cyc = 0; we_cyc = 0; bad = 0; extra = 0; acked = 0;
    addr_bus[k] = a; mem_bus_out[k] = d; mem_write[k] = wr; mem_read[k] = rd;
    while (!acked && lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (lat == 1) begin
        addr_bus[k]    = ~a;
        mem_bus_out[k] = ~d;
      end
      if (mem_ack[k]) acked = 1;
      else begin
        if (!oe_n[k]) oe_cyc++;
        if (!we_n[k]) we_cyc++;
        if (!oe_n[k] && !we_n[k]) bad++;
        if (sram_addr[k] !== {4'h0, a}) bad++;
        if ({ce_n[k], lb_n[k], ub_n[k]} !== 3'b000) bad++;
        if (dq_en_mon[k] !== (wr && lat <= w + 3)) bad++;
        if (!we_n[k] && dq_mon[k] !== d) bad++;
      end
    end
    check($sformatf("%s_latency", tag), lat, wr ? w + 4 : w + 2);
    check($sformatf("%s_pulse", tag), wr ? we_cyc : oe_cyc, w + 1);
    check($sformatf("%s_other_strobe", tag), wr ? oe_cyc : we_cyc, 0);
    check($sformatf("%s_bus_violations", tag), bad, 0);
    check($sformatf("%s_mem_bus_in", tag), mem_bus_in[k], exp_rd);
    check($sformatf("%s_ack_strobes", tag),
          {ce_n[k], lb_n[k], ub_n[k], oe_n[k], we_n[k], dq_en_mon[k]}, 6'b111110);
    for (int i = 0; i < hold + 2; i++) begin
      if (i == hold) begin
        mem_read[k]  = 1'b0;
        mem_write[k] = 1'b0;
      end
      @(posedge clock); #1;
      if (mem_ack[k] || !ce_n[k] || !oe_n[k] || !we_n[k]) extra++;
    end
    check($sformatf("%s_after_ack_activity", tag), extra, 0);
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] sb [logic [15:0]];
  logic [15:0] rnd_addr [64];
  logic [15:0] last_rd;
  logic [15:0] a, d;
  int          acks;

  initial begin
    vecs[0] = '{1'b1, 16'h0012, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 16'h0012, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 16'hFFFF, 16'h1234, 16'hBEEF};
    vecs[3] = '{1'b1, 16'h0000, 16'hA5A5, 16'hBEEF};
    vecs[4] = '{1'b0, 16'hFFFF, 16'h0000, 16'h1234};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000, 16'hA5A5};
    vecs[6] = '{1'b1, 16'h0012, 16'h0001, 16'hA5A5};
    vecs[7] = '{1'b0, 16'h0012, 16'h0000, 16'h0001};

    for (int k = 0; k < NDUT; k++) begin
      addr_bus[k] = 16'h0; mem_bus_out[k] = 16'h0; mem_read[k] = 1'b0; mem_write[k] = 1'b0;
    end

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_mem_ack", mem_ack[0], 1'b0);
    check("rst_mem_bus_in", mem_bus_in[0], 16'h0000);
    check("rst_sram_addr", sram_addr[0], 20'h00000);
    check("rst_strobes", {ce_n[0], oe_n[0], we_n[0], lb_n[0], ub_n[0]}, 5'b11111);
    check("rst_dq_en", dq_en_mon[0], 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Directed table on the WAIT_CYCLES=1 controller
    for (int i = 0; i < 8; i++) begin
      do_access(0, vecs[i].wr, !vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 0,
                $sformatf("vec%0d", i));
      if (vecs[i].wr)
        check($sformatf("vec%0d_sram_word", i), g_dut[0].mem[vecs[i].addr], vecs[i].wdata);
    end

    // Request held four cycles past mem_ack
    do_access(0, 1'b1, 1'b0, 16'h0100, 16'h5A5A, 16'h0001, 4, "held_wr");
    do_access(0, 1'b0, 1'b1, 16'h0100, 16'h0000, 16'h5A5A, 0, "held_rd_back");

    // Read and write together: only the write happens
    do_access(0, 1'b1, 1'b1, 16'h0040, 16'h7777, 16'h5A5A, 0, "both");
    do_access(0, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h7777, 0, "both_rd_back");

    // Reset during WPULSE
    addr_bus[0] = 16'h0050; mem_bus_out[0] = 16'hDEAD; mem_write[0] = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("abort_in_wpulse", we_n[0], 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_strobes", {ce_n[0], oe_n[0], we_n[0], lb_n[0], ub_n[0]}, 5'b11111);
    check("abort_dq_en", dq_en_mon[0], 1'b0);
    reset = 1'b0;
    mem_write[0] = 1'b0;
    acks = (mem_ack[0] === 1'b1) ? 1 : 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (mem_ack[0] === 1'b1) acks++;
    end
    check("abort_no_ack", acks, 0);
    do_access(0, 1'b0, 1'b1, 16'h0012, 16'h0000, 16'h0001, 0, "abort_rd_after");

    // Read request held across reset release
    reset = 1'b1;
    addr_bus[0] = 16'h0040; mem_read[0] = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_hold_mem_bus_in", mem_bus_in[0], 16'h0000);
    check("rst_hold_ce_n", ce_n[0], 1'b1);
    reset = 1'b0;
    do_access(0, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h7777, 0, "rst_hold");

    // Alternating random writes and reads at WAIT_CYCLES 0 and 15
    for (int k = 1; k < NDUT; k++) begin
      sb.delete();
      last_rd = 16'h0000;
      for (int i = 0; i < 64; i++) begin
        int j;
        a = 16'($urandom_range(0, 65535));
        d = 16'($urandom);
        rnd_addr[i] = a;
        sb[a] = d;
        do_access(k, 1'b1, 1'b0, a, d, last_rd, 0, $sformatf("w%0d_wr%0d", wait_of(k), i));
        j = $urandom_range(0, i);
        last_rd = sb[rnd_addr[j]];
        do_access(k, 1'b0, 1'b1, rnd_addr[j], 16'h0000, last_rd, 0,
                  $sformatf("w%0d_rd%0d", wait_of(k), i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
